result_line_packer: RTL

RESULT_LINE_PACKER -- requirements
Module: result_line_packer

---
 rtl/result_line_packer_pkg.sv | 20 ++
 rtl/result_line_packer_if.sv | 37 +++
 rtl/result_line_packer.sv | 104 ++++++++++
 3 files changed

// File: rtl/result_line_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_packer_pkg
// Description : Shared widths and types for the result-line packer and the
//               AFU c1Tx write path that consumes its packed lines.
// Revision    : 1.0 - initial release
// ============================================================================
package result_packer_pkg;

    localparam int DATA_LEN  = 32;
    localparam int LINE_BITS = 512;
    localparam int LANES     = LINE_BITS / DATA_LEN;
    localparam int CNT_W     = $clog2(LANES) + 1;

    // Lane count of a line: 0..LANES, hence one extra bit over log2(LANES)
    typedef logic [CNT_W-1:0]     t_lane_cnt;
    typedef logic [LINE_BITS-1:0] t_line;

endpackage : result_packer_pkg
`default_nettype wire

// File: rtl/result_line_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : result_line_packer_if
// Description : Word-in / line-out handshake bundle of the result-line packer.
//               master = word producer and line consumer, slave = packer.
// Revision    : 1.0 - initial release
// ============================================================================
interface result_line_packer_if #(
    parameter int DATA_LEN  = result_packer_pkg::DATA_LEN,
    parameter int LINE_BITS = result_packer_pkg::LINE_BITS
);
    localparam int LANES = LINE_BITS / DATA_LEN;
    localparam int CNT_W = $clog2(LANES) + 1;

    logic                 in_valid;
    logic [DATA_LEN-1:0]  in_data;
    logic                 in_ready;
    logic                 flush;
    logic                 out_valid;
    logic [LINE_BITS-1:0] out_data;
    logic [CNT_W-1:0]     out_count;
    logic                 out_ready;
    logic [31:0]          lines_emitted;
    logic                 busy;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_count, lines_emitted, busy
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_count, lines_emitted, busy
    );

endinterface : result_line_packer_if
`default_nettype wire

// File: rtl/result_line_packer.sv
`default_nettype none
// ============================================================================
// Module      : result_line_packer
// Description : Packs DATA_LEN-bit multiplier results into LINE_BITS cache
//               lines. Lines close when full or on flush; a single output
//               register holds the line until the write path takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module result_line_packer #(
    parameter int DATA_LEN  = result_packer_pkg::DATA_LEN,
    parameter int LINE_BITS = result_packer_pkg::LINE_BITS
) (
    input  wire                   clk,
    input  wire                   reset,
    result_line_packer_if.slave   bus
);

    localparam int LANES = LINE_BITS / DATA_LEN;
    localparam int CNT_W = $clog2(LANES) + 1;

    logic [CNT_W-1:0]     r_asm_cnt;
    logic [LINE_BITS-1:0] r_asm_data;
    logic                 r_flush_pending;
    logic                 r_out_valid;
    logic [LINE_BITS-1:0] r_out_data;
    logic [CNT_W-1:0]     r_out_count;
    logic [31:0]          r_lines_emitted;

    logic w_in_ready;
    logic w_accept;
    logic w_line_closed;
    logic w_transfer;
    logic w_handshake;

    // in_ready comes from registers only, so upstream never sees a path
    // from out_ready or in_valid.
    assign w_in_ready    = (r_asm_cnt < CNT_W'(LANES)) && !r_flush_pending;
    assign w_accept      = bus.in_valid && w_in_ready;
    assign w_line_closed = (r_asm_cnt == CNT_W'(LANES)) ||
                           (r_flush_pending && (r_asm_cnt != '0));
    assign w_transfer    = w_line_closed && (!r_out_valid || bus.out_ready);
    assign w_handshake   = r_out_valid && bus.out_ready;

    // Assembly register: write accepted word into its lane, clear on hand-off.
    // A closed line blocks in_ready, so accept and transfer never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_asm_cnt  <= '0;
            r_asm_data <= '0;
        end else if (w_transfer) begin
            r_asm_cnt  <= '0;
            r_asm_data <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < LANES; k++) begin
                if (r_asm_cnt == CNT_W'(k)) begin
                    r_asm_data[k*DATA_LEN +: DATA_LEN] <= bus.in_data;
                end
            end
            r_asm_cnt <= r_asm_cnt + CNT_W'(1);
        end
    end

    // Flush request: held until the partial line leaves, or dropped when
    // there turns out to be nothing to close (empty or already-taken line).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flush_pending <= 1'b0;
        end else if (bus.flush) begin
            r_flush_pending <= 1'b1;
        end else if (w_transfer || (r_asm_cnt == '0)) begin
            r_flush_pending <= 1'b0;
        end
    end

    // Output register and hand-off counter; data stays stable while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_count     <= '0;
            r_lines_emitted <= '0;
        end else begin
            if (w_transfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_asm_data;
                r_out_count <= r_asm_cnt;
            end else if (w_handshake) begin
                r_out_valid <= 1'b0;
            end
            if (w_handshake) begin
                r_lines_emitted <= r_lines_emitted + 32'd1;
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.out_count     = r_out_count;
    assign bus.lines_emitted = r_lines_emitted;
    assign bus.busy          = (r_asm_cnt != '0) || r_out_valid || r_flush_pending;

endmodule : result_line_packer
`default_nettype wire
